// File: rtl/pipe_skid_stage.sv
// Pipeline buffer stage: DEPTH-entry circular buffer with valid/ready handshake,
// global enable (rdy_in), flush, and asynchronous active-high reset.
module pipe_skid_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;
  logic w_flush;
  logic w_not_full;

  assign w_not_full = (r_count < DEPTH_C);
  // Gated by rst_in so the stage never advertises space while held in reset.
  assign in_ready   = rdy_in & w_not_full & ~flush_in & ~rst_in;
  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? r_mem[r_rptr] : '0;
  assign count_out  = r_count;

  assign w_push  = in_valid & in_ready;
  assign w_pop   = out_valid & out_ready & rdy_in & ~flush_in;
  assign w_flush = rdy_in & flush_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is not reset; out_data is masked by out_valid instead.
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage (WIDTH=32, DEPTH=2) against a
// queue-based reference model with directed and randomized stimulus.
module tb_pipe_skid_stage;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 4;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             rdy_in;
  logic             flush_in;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count_out;

  int n_pass  = 0;
  int n_total = 0;

  logic [WIDTH-1:0] mq[$];

  pipe_skid_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic exp_valid();
    return mq.size() != 0;
  endfunction

  function automatic logic [WIDTH-1:0] exp_data();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  function automatic logic [CW-1:0] exp_count();
    return CW'(mq.size());
  endfunction

  function automatic logic exp_in_ready();
    return rdy_in && !flush_in && !rst_in && (mq.size() < DEPTH);
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] d,
                       input logic ordy, input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    rdy_in    = rdy;
    flush_in  = fl;
  endtask

  // Advance one clock; the model consumes the inputs that were stable at the edge.
  task automatic tick();
    bit do_pop;
    bit do_push;
    do_pop  = 0;
    do_push = 0;
    if (rdy_in && !rst_in) begin
      if (flush_in) begin
        mq.delete();
      end else begin
        do_pop  = (mq.size() != 0) && out_ready;
        do_push = in_valid && (mq.size() < DEPTH);
      end
    end
    @(posedge clk_in);
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(in_data);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    rst_in = 1'b1;
    #1;
    n_total++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
    else n_pass++;
    n_total++;
    if (out_data !== '0)
      $display("FAIL reset_out_data got=%h exp=0", out_data);
    else n_pass++;
    n_total++;
    if (count_out !== '0)
      $display("FAIL reset_count got=%0d exp=0", count_out);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b0)
      $display("FAIL reset_in_ready got=%0b exp=0", in_ready);
    else n_pass++;
    @(negedge clk_in);
    rst_in = 1'b0;
    mq.delete();
    // First push at the first rising edge after reset release
    drive(1'b1, 32'h0000_00F1, 1'b0, 1'b1, 1'b0);
    #1;
    n_total++;
    if (in_ready !== 1'b1)
      $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (out_data !== 32'h0000_00F1 || count_out !== 4'd1)
      $display("FAIL post_reset_push got=%h/%0d exp=000000f1/1", out_data, count_out);
    else n_pass++;
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_passthrough();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 32'h11;
    vals[1] = 32'h22;
    vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 1'b1, 1'b1, 1'b0);
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_data !== vals[i] || count_out !== 4'd1)
        $display("FAIL passthrough_%0d got=%0b/%h/%0d exp=1/%h/1",
                 i, out_valid, out_data, count_out, vals[i]);
      else n_pass++;
    end
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick();
    n_total++;
    if (out_valid !== 1'b0 || count_out !== 4'd0)
      $display("FAIL passthrough_drain got=%0b/%0d exp=0/0", out_valid, count_out);
    else n_pass++;
  endtask

  task automatic test_full();
    drive(1'b1, 32'hA, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
    #1;
    n_total++;
    if (count_out !== 4'd2 || in_ready !== 1'b0)
      $display("FAIL full_state got=%0d/%0b exp=2/0", count_out, in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (count_out !== 4'd2 || out_data !== 32'hA)
      $display("FAIL full_no_accept got=%0d/%h exp=2/0000000a", count_out, out_data);
    else n_pass++;
    drive(1'b1, 32'hC, 1'b1, 1'b1, 1'b0);
    #1;
    n_total++;
    if (in_ready !== 1'b0)
      $display("FAIL full_no_pushthrough got=%0b exp=0", in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (count_out !== 4'd1 || out_data !== 32'hB)
      $display("FAIL full_drain_a got=%0d/%h exp=1/0000000b", count_out, out_data);
    else n_pass++;
    tick();
    n_total++;
    if (count_out !== 4'd1 || out_data !== 32'hC)
      $display("FAIL full_accept_c got=%0d/%h exp=1/0000000c", count_out, out_data);
    else n_pass++;
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick();
    n_total++;
    if (out_valid !== 1'b0 || out_data !== '0)
      $display("FAIL full_empty got=%0b/%h exp=0/0", out_valid, out_data);
    else n_pass++;
    // Empty: out_ready must not underflow the count
    tick();
    n_total++;
    if (count_out !== 4'd0)
      $display("FAIL empty_underflow got=%0d exp=0", count_out);
    else n_pass++;
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h5, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h6, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h7, 1'b1, 1'b1, 1'b1);
    #1;
    n_total++;
    if (in_ready !== 1'b0)
      $display("FAIL flush_in_ready got=%0b exp=0", in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (count_out !== 4'd0 || out_valid !== 1'b0 || out_data !== '0)
      $display("FAIL flush_clear got=%0d/%0b/%h exp=0/0/0", count_out, out_valid, out_data);
    else n_pass++;
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (out_valid !== 1'b0)
        $display("FAIL flush_discard_%0d got=%0b/%h exp=0", i, out_valid, out_data);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h9, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (out_data !== 32'h9 || count_out !== 4'd1 || in_ready !== 1'b0)
        $display("FAIL stall_%0d got=%h/%0d/%0b exp=00000009/1/0",
                 i, out_data, count_out, in_ready);
      else n_pass++;
    end
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick();
    n_total++;
    if (count_out !== 4'd0)
      $display("FAIL stall_release got=%0d exp=0", count_out);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h21, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h22, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    n_total++;
    if (count_out !== 4'd2)
      $display("FAIL async_pre got=%0d exp=2", count_out);
    else n_pass++;
    #1;
    rst_in = 1'b1;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || count_out !== 4'd0 || out_data !== '0)
      $display("FAIL async_reset got=%0b/%0d/%h exp=0/0/0", out_valid, count_out, out_data);
    else n_pass++;
    #1;
    rst_in = 1'b0;
    mq.delete();
    tick();
    n_total++;
    if (count_out !== 4'd0)
      $display("FAIL async_post got=%0d exp=0", count_out);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] sent[$];
    logic [WIDTH-1:0] got[$];
    int idx;
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + WIDTH'(idx), i[0], 1'b1, 1'b0);
      #1;
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_ready) begin
        sent.push_back(in_data);
        idx++;
      end
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
    end
    n_total++;
    if (got.size() != sent.size())
      $display("FAIL wrap_count got=%0d exp=%0d", got.size(), sent.size());
    else n_pass++;
    for (int i = 0; i < sent.size(); i++) begin
      n_total++;
      if (i >= got.size() || got[i] !== sent[i])
        $display("FAIL wrap_order_%0d got=%h exp=%h", i,
                 (i < got.size()) ? got[i] : 32'hx, sent[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
      #1;
      n_total++;
      if (in_ready !== exp_in_ready()) begin
        if (errs < 10)
          $display("FAIL rand_in_ready_%0d got=%0b exp=%0b", i, in_ready, exp_in_ready());
        errs++;
      end else n_pass++;
      tick();
      n_total++;
      if (out_valid !== exp_valid() || out_data !== exp_data() || count_out !== exp_count()) begin
        if (errs < 10)
          $display("FAIL rand_out_%0d got=%0b/%h/%0d exp=%0b/%h/%0d", i,
                   out_valid, out_data, count_out, exp_valid(), exp_data(), exp_count());
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst_in = 1'b1;
    @(negedge clk_in);
    test_reset();
    test_passthrough();
    test_full();
    test_flush();
    test_stall();
    test_async_reset();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter WIDTH, default 32: payload bits per entry; legal range 1..256.
REQ-002 Parameter DEPTH, default 2: buffer entries; SHALL be a power of two in 2..8.
REQ-003 Parameter CW, default 4: occupancy counter width; SHALL be at least clog2(DEPTH)+1.
REQ-004 clk_in  input  1  single clock; all state updates on rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 rdy_in  input  1  global enable; low freezes all state.
REQ-007 flush_in  input  1  flush request, e.g. branch taken; discards all entries.
REQ-008 in_valid  input  1  upstream entry offered.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 in_ready  output  1  stage accepts an entry this cycle.
REQ-011 out_valid  output  1  head entry presented downstream.
REQ-012 out_data  output  WIDTH  head payload; all zeros when out_valid is low (bubble).
REQ-013 out_ready  input  1  downstream consumes the head this cycle.
REQ-014 count_out  output  CW  current occupancy, 0..DEPTH.

Function
REQ-015 Storage: circular buffer of DEPTH entries, with write pointer, read pointer and occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-016 in_ready SHALL equal rdy_in and (count < DEPTH) and not flush_in, combinationally.
REQ-017 Push occurs on an edge where in_valid and in_ready are both high: entry written at the write pointer, write pointer +1 mod DEPTH.
REQ-018 Pop occurs on an edge where out_valid, out_ready and rdy_in are high and flush_in is low: read pointer +1 mod DEPTH.
REQ-019 Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-020 out_valid SHALL equal (count != 0); out_data SHALL equal the entry at the read pointer when out_valid is high, else zero.
REQ-021 Latency: an entry pushed at edge N is visible on out_data immediately after edge N when the buffer was empty; there is no combinational in_data-to-out_data path.
REQ-022 Throughput: one entry per cycle sustained when out_ready stays high; count holds at 1.
REQ-023 Full (count == DEPTH): in_ready low even when out_ready is high; no push-through when full; pop still permitted.
REQ-024 Empty: out_ready is ignored; count never underflows.
REQ-025 flush_in high with rdy_in high: at the next edge count, the write pointer and the read pointer all become 0, and the same-cycle input is discarded; flush overrides push and pop.
REQ-026 flush_in high with rdy_in low: ignored; flush is gated by rdy_in.
REQ-027 rdy_in low: no push, no pop, no flush; pointers, count and storage hold; outputs stay stable.
REQ-028 Storage contents are not cleared on flush; the bubble zeroing on out_data is purely from out_valid.

Reset
REQ-029 While rst_in is high, asynchronously: count, write pointer and read pointer are 0, out_valid is 0, out_data is 0, in_ready is 0, and count_out is 0.
REQ-030 Storage need not be reset; out_data is still zero through REQ-020.
REQ-031 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-032 The first push is possible at the first rising edge after rst_in deasserts, provided rdy_in is high.

Verification (WIDTH=32, DEPTH=2)
REQ-033 Pass-through: push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_data shows 0x11, 0x22, 0x33 one cycle after each push; count stays 1.
REQ-034 Fill/full: out_ready=0, push 0xA, 0xB -> count=2, in_ready=0; a third offer 0xC is not accepted; set out_ready=1 -> 0xA then 0xB drain, and 0xC is accepted when count<2.
REQ-035 Flush: count=2 holding 0x5, 0x6; assert flush_in with in_valid=1 and in_data=0x7 -> next cycle count=0, out_valid=0, out_data=0; 0x7 is never output.
REQ-036 rdy_in stall: count=1 with head 0x9; rdy_in=0 for 3 cycles with in_valid=1, out_ready=1 and flush_in=1 -> state frozen, out_data stays 0x9, count stays 1.
REQ-037 Async reset: count=2, pulse rst_in between clock edges -> out_valid=0 and count_out=0 before the next edge.
REQ-038 Wrap: 10 push/pop cycles alternating with out_ready toggled -> output order equals input order, with no loss and no duplication.
